// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised oversampling UART receiver.
// The helpers are pure combinational functions so the sampler and the FSM agree on one definition.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_RECOVER = 3'd5
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Bit decision for one window: 1 when at least half the samples were 1, so a tie gives 1.
    function automatic logic majority(input logic [31:0] ones_cnt, input logic [31:0] win_len);
        logic [32:0] twice;
        twice    = {ones_cnt, 1'b0};
        majority = (twice >= {1'b0, win_len}) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic expected_parity(input logic [8:0] bits, input int mode);
        expected_parity = (mode == PAR_ODD) ? ~(^bits) : (^bits);
    endfunction

endpackage

// File: rtl/uart_bit_sampler.sv
// Counts rx_s ones across one OVERSAMPLE-cycle window and reports the majority bit
// on the window's last sample, together with a window-end strobe.
module uart_bit_sampler #(
    parameter int OVERSAMPLE = 16
) (
    input  logic i_clkx16,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_rx_s,
    output logic o_win_end,
    output logic o_bit_val
);
    import uart_pkg::*;

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int ONES_W = $clog2(OVERSAMPLE + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0]  r_cnt;
    logic [ONES_W-1:0] r_ones;
    logic [ONES_W-1:0] w_ones_tot;
    logic              w_win_end;

    // The current sample is folded in so the decision includes the window's last sample.
    always_comb begin
        w_ones_tot = r_ones + ONES_W'(i_rx_s);
        w_win_end  = (~i_clear) & ((r_cnt == CNT_LAST) ? 1'b1 : 1'b0);
    end

    assign o_win_end = w_win_end;
    assign o_bit_val = majority(32'(w_ones_tot), 32'(OVERSAMPLE));

    // Sample counter and ones accumulator; both restart at every window end.
    always_ff @(posedge i_clkx16) begin
        if (i_reset) begin
            r_cnt  <= '0;
            r_ones <= '0;
        end else if (i_clear || w_win_end) begin
            r_cnt  <= '0;
            r_ones <= '0;
        end else begin
            r_cnt  <= r_cnt + CNT_ONE;
            r_ones <= w_ones_tot;
        end
    end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronises rx, sequences bit windows through the frame
// and delivers each good word with a one-cycle load pulse; bad stop bits drop the word.
module uart_rx_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int MSB_FIRST  = 1
) (
    input  logic                 i_clkx16,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_load,
    output logic                 o_parity_err,
    output logic                 o_frame_err,
    output logic                 o_busy
);
    import uart_pkg::*;

    localparam int BIT_W = $clog2(DATA_BITS);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
    localparam logic STOP_LAST  = (STOP_BITS == 2) ? 1'b1 : 1'b0;
    localparam logic HAS_PARITY = (PARITY != PAR_NONE) ? 1'b1 : 1'b0;

    logic r_sync1;
    logic r_sync2;
    logic w_rx_s;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [BIT_W-1:0]     r_bit_idx;
    logic [BIT_W-1:0]     w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] w_shift_nxt;
    logic [DATA_BITS-1:0] w_shifted;
    logic                 r_stop_idx;
    logic                 w_stop_idx_nxt;
    logic                 r_par_bad;
    logic                 w_par_bad_nxt;
    logic                 r_armed;
    logic                 w_armed_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 r_load;
    logic                 w_load_nxt;
    logic                 r_parity_err;
    logic                 w_parity_err_nxt;
    logic                 r_frame_err;
    logic                 w_frame_err_nxt;
    logic                 r_busy;

    logic w_clear;
    logic w_win_end;
    logic w_bit_val;

    assign w_rx_s  = r_sync2;
    assign w_clear = ((r_state == ST_IDLE) || (r_state == ST_RECOVER)) ? 1'b1 : 1'b0;

    // Two-flop synchroniser; flops reset high so reset never looks like a start bit.
    always_ff @(posedge i_clkx16) begin
        if (i_reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    uart_bit_sampler #(
        .OVERSAMPLE(OVERSAMPLE)
    ) u_sampler (
        .i_clkx16 (i_clkx16),
        .i_reset  (i_reset),
        .i_clear  (w_clear),
        .i_rx_s   (w_rx_s),
        .o_win_end(w_win_end),
        .o_bit_val(w_bit_val)
    );

    assign w_shifted = (MSB_FIRST != 0) ? {r_shift[DATA_BITS-2:0], w_bit_val}
                                        : {w_bit_val, r_shift[DATA_BITS-1:1]};

    // Next-state and datapath decisions, all taken at window ends.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_idx_nxt    = r_bit_idx;
        w_shift_nxt      = r_shift;
        w_stop_idx_nxt   = r_stop_idx;
        w_par_bad_nxt    = r_par_bad;
        w_data_nxt       = r_data;
        w_load_nxt       = 1'b0;
        w_parity_err_nxt = 1'b0;
        w_frame_err_nxt  = 1'b0;
        w_armed_nxt      = r_armed | (((r_state == ST_IDLE) && w_rx_s) ? 1'b1 : 1'b0);

        case (r_state)
            ST_IDLE: begin
                if (r_armed && !w_rx_s) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (w_win_end) begin
                    if (w_bit_val) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt    = ST_DATA;
                        w_bit_idx_nxt  = '0;
                        w_stop_idx_nxt = 1'b0;
                        w_par_bad_nxt  = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_START;
                end
            end
            ST_DATA: begin
                if (w_win_end) begin
                    w_shift_nxt = w_shifted;
                    if (r_bit_idx == BIT_LAST) begin
                        w_bit_idx_nxt = '0;
                        w_state_nxt   = HAS_PARITY ? ST_PARITY : ST_STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + BIT_ONE;
                    end
                end else begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (w_win_end) begin
                    w_par_bad_nxt = (w_bit_val != expected_parity(9'(r_shift), PARITY)) ? 1'b1 : 1'b0;
                    w_state_nxt   = ST_STOP;
                end else begin
                    w_state_nxt = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (w_win_end) begin
                    if (!w_bit_val) begin
                        w_frame_err_nxt = 1'b1;
                        w_state_nxt     = ST_RECOVER;
                    end else if (r_stop_idx == STOP_LAST) begin
                        w_data_nxt       = r_shift;
                        w_load_nxt       = 1'b1;
                        w_parity_err_nxt = r_par_bad;
                        w_state_nxt      = ST_IDLE;
                    end else begin
                        w_stop_idx_nxt = 1'b1;
                    end
                end else begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_RECOVER: begin
                if (w_rx_s) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_RECOVER;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clkx16) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame datapath and registered outputs.
    always_ff @(posedge i_clkx16) begin
        if (i_reset) begin
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_stop_idx   <= 1'b0;
            r_par_bad    <= 1'b0;
            r_armed      <= 1'b0;
            r_data       <= '0;
            r_load       <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_bit_idx    <= w_bit_idx_nxt;
            r_shift      <= w_shift_nxt;
            r_stop_idx   <= w_stop_idx_nxt;
            r_par_bad    <= w_par_bad_nxt;
            r_armed      <= w_armed_nxt;
            r_data       <= w_data_nxt;
            r_load       <= w_load_nxt;
            r_parity_err <= w_parity_err_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_busy       <= (w_state_nxt != ST_IDLE) ? 1'b1 : 1'b0;
        end
    end

    assign o_data       = r_data;
    assign o_load       = r_load;
    assign o_parity_err = r_parity_err;
    assign o_frame_err  = r_frame_err;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three parameterisations, directed frames built
// sample-by-sample, expected words queued at send time and popped on each load pulse.
module tb_uart_rx_param;
    import uart_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b;
    logic [8:0] data_c;
    logic load_a, perr_a, ferr_a, busy_a;
    logic load_b, perr_b, ferr_b, busy_b;
    logic load_c, perr_c, ferr_c, busy_c;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int k_edge = 0;
    int ld_a = 0, ld_b = 0, ld_c = 0;
    int fe_a = 0, fe_b = 0, fe_c = 0;
    int ld_cyc_a = -1;
    logic [9:0] exp_a[$];
    logic [9:0] exp_b[$];
    logic [9:0] exp_c[$];
    bit pin_q[$];
    logic [8:0] c_words [0:2] = '{9'h1A5, 9'h0F3, 9'h100};

    always #5 clk = ~clk;

    uart_rx_param u_a (
        .i_clkx16(clk), .i_reset(rst), .i_rx(rx_a), .o_data(data_a),
        .o_load(load_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_busy(busy_a)
    );

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) u_b (
        .i_clkx16(clk), .i_reset(rst), .i_rx(rx_b), .o_data(data_b),
        .o_load(load_b), .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_busy(busy_b)
    );

    uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(8), .PARITY(0), .STOP_BITS(2), .MSB_FIRST(1)) u_c (
        .i_clkx16(clk), .i_reset(rst), .i_rx(rx_c), .o_data(data_c),
        .o_load(load_c), .o_parity_err(perr_c), .o_frame_err(ferr_c), .o_busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Pops the scoreboard on every load/parity pulse of each receiver.
    task automatic mon();
        logic [9:0] e;
        if (load_a === 1'b1 || perr_a === 1'b1) begin
            check("a_load_with_perr", 32'(load_a), 32'd1);
            check("a_busy_at_load", 32'(busy_a), 32'd0);
            check("a_ferr_at_load", 32'(ferr_a), 32'd0);
            check("a_sb_nonempty", 32'(exp_a.size() != 0), 32'd1);
            if (exp_a.size() != 0) begin
                e = exp_a.pop_front();
                check("a_data", 32'(data_a), 32'(e[8:0]));
                check("a_perr", 32'(perr_a), 32'(e[9]));
            end
        end
        if (load_a === 1'b1) begin ld_a++; ld_cyc_a = cyc; end
        if (ferr_a === 1'b1) fe_a++;
        if (load_b === 1'b1 || perr_b === 1'b1) begin
            check("b_load_with_perr", 32'(load_b), 32'd1);
            check("b_sb_nonempty", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
                e = exp_b.pop_front();
                check("b_data", 32'(data_b), 32'(e[8:0]));
                check("b_perr", 32'(perr_b), 32'(e[9]));
            end
        end
        if (load_b === 1'b1) ld_b++;
        if (ferr_b === 1'b1) fe_b++;
        if (load_c === 1'b1 || perr_c === 1'b1) begin
            check("c_load_with_perr", 32'(load_c), 32'd1);
            check("c_sb_nonempty", 32'(exp_c.size() != 0), 32'd1);
            if (exp_c.size() != 0) begin
                e = exp_c.pop_front();
                check("c_data", 32'(data_c), 32'(e[8:0]));
                check("c_perr", 32'(perr_c), 32'(e[9]));
            end
        end
        if (load_c === 1'b1) ld_c++;
        if (ferr_c === 1'b1) fe_c++;
    endtask

    // One clock: monitor at the falling edge, then leave the bench 1 time unit past the rising edge.
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_rx(input int sel, input logic v);
        case (sel)
            0: rx_a = v;
            1: rx_b = v;
            2: rx_c = v;
            default: ;
        endcase
    endtask

    task automatic add_win(input int os, input bit v);
        for (int j = 0; j < os; j++) pin_q.push_back(v);
    endtask

    // pin_q[0] is the first low sample (edge k); window w then occupies pin_q[1+w*os .. os+w*os].
    task automatic build(input int os, input int dbits, input logic [8:0] word, input bit msb,
                         input int par, input bit par_flip, input int nstop, input bit stop_bad);
        bit p;
        pin_q.delete();
        pin_q.push_back(1'b0);
        add_win(os, 1'b0);
        for (int i = 0; i < dbits; i++) add_win(os, msb ? word[dbits-1-i] : word[i]);
        if (par != 0) begin
            p = (^word) ^ (par == 2) ^ par_flip;
            add_win(os, p);
        end
        for (int s = 0; s < nstop; s++) add_win(os, ~stop_bad);
    endtask

    task automatic noise(input int os, input int nwin);
        int base, p1, p2;
        for (int w = 0; w < nwin; w++) begin
            base = 1 + w * os;
            p1 = int'($urandom_range(os - 1, 0));
            p2 = (p1 + 1 + int'($urandom_range(os - 2, 0))) % os;
            pin_q[base + p1] = ~pin_q[base + p1];
            pin_q[base + p2] = ~pin_q[base + p2];
        end
    endtask

    task automatic tie(input int os, input int w);
        for (int j = 0; j < os; j++) pin_q[1 + w * os + j] = (j >= os / 2);
    endtask

    task automatic drive(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            set_rx(sel, pin_q[i]);
            tick();
            if (i == 0) k_edge = cyc;
        end
        set_rx(sel, 1'b1);
    endtask

    initial begin
        int l0, f0;
        rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
        idle(3);
        check("rst_data", 32'(data_a), 32'd0);
        check("rst_load", 32'(load_a), 32'd0);
        check("rst_perr", 32'(perr_a), 32'd0);
        check("rst_ferr", 32'(ferr_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_state", 32'(u_a.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        idle(4);

        // Defaults, 0xA5 with exact load timing.
        build(16, 8, 9'h0A5, 1'b1, 0, 1'b0, 1, 1'b0);
        exp_a.push_back({1'b0, 9'h0A5});
        drive(0, pin_q.size());
        idle(6);
        check("a5_latency", 32'(ld_cyc_a), 32'(k_edge + 2 + 160));
        check("a5_count", 32'(ld_a), 32'd1);
        check("a5_hold", 32'(data_a), 32'h0A5);

        // Bad stop bit then line held low.
        l0 = ld_a; f0 = fe_a;
        build(16, 8, 9'h03C, 1'b1, 0, 1'b0, 1, 1'b1);
        drive(0, pin_q.size());
        for (int i = 0; i < 40; i++) begin set_rx(0, 1'b0); tick(); end
        check("fe_pulse", 32'(fe_a), 32'(f0 + 1));
        check("fe_no_load", 32'(ld_a), 32'(l0));
        check("fe_data_kept", 32'(data_a), 32'h0A5);
        check("fe_recover", 32'(u_a.r_state), 32'(ST_RECOVER));
        check("fe_busy", 32'(busy_a), 32'd1);
        set_rx(0, 1'b1);
        idle(4);
        check("fe_idle_busy", 32'(busy_a), 32'd0);
        check("fe_idle_state", 32'(u_a.r_state), 32'(ST_IDLE));

        // Five-cycle glitch on an idle line.
        l0 = ld_a; f0 = fe_a;
        for (int i = 0; i < 5; i++) begin set_rx(0, 1'b0); tick(); end
        set_rx(0, 1'b1);
        idle(6);
        check("gl_in_start", 32'(busy_a), 32'd1);
        idle(20);
        check("gl_busy", 32'(busy_a), 32'd0);
        check("gl_state", 32'(u_a.r_state), 32'(ST_IDLE));
        check("gl_no_load", 32'(ld_a), 32'(l0));
        check("gl_no_ferr", 32'(fe_a), 32'(f0));

        // LSB-first, even parity.
        build(16, 8, 9'h03C, 1'b0, 1, 1'b0, 1, 1'b0);
        exp_b.push_back({1'b0, 9'h03C});
        drive(1, pin_q.size());
        idle(6);
        check("b_good_count", 32'(ld_b), 32'd1);
        build(16, 8, 9'h03C, 1'b0, 1, 1'b1, 1, 1'b0);
        exp_b.push_back({1'b1, 9'h03C});
        drive(1, pin_q.size());
        idle(6);
        check("b_bad_par_count", 32'(ld_b), 32'd2);
        build(16, 8, 9'h007, 1'b0, 1, 1'b0, 1, 1'b0);
        exp_b.push_back({1'b0, 9'h007});
        drive(1, pin_q.size());
        idle(6);
        check("b_odd_ones_data", 32'(data_b), 32'h007);
        check("b_no_ferr", 32'(fe_b), 32'd0);

        // OVERSAMPLE 8, 9 bits, 2 stops, two corrupted samples per window.
        for (int i = 0; i < 3; i++) begin
            build(8, 9, c_words[i], 1'b1, 0, 1'b0, 2, 1'b0);
            noise(8, 12);
            exp_c.push_back({1'b0, c_words[i]});
            drive(2, pin_q.size());
            idle(4);
        end
        build(8, 9, 9'h055, 1'b1, 0, 1'b0, 2, 1'b0);
        tie(8, 4);
        exp_c.push_back({1'b0, 9'h075});
        drive(2, pin_q.size());
        idle(4);
        check("c_count", 32'(ld_c), 32'd4);
        check("c_tie_data", 32'(data_c), 32'h075);
        check("c_no_ferr", 32'(fe_c), 32'd0);

        // Back-to-back frames with no idle gap.
        l0 = ld_a;
        build(16, 8, 9'h05A, 1'b1, 0, 1'b0, 1, 1'b0);
        exp_a.push_back({1'b0, 9'h05A});
        drive(0, pin_q.size());
        build(16, 8, 9'h0C3, 1'b1, 0, 1'b0, 1, 1'b0);
        exp_a.push_back({1'b0, 9'h0C3});
        drive(0, pin_q.size());
        idle(6);
        check("b2b_count", 32'(ld_a), 32'(l0 + 2));
        check("b2b_latency", 32'(ld_cyc_a), 32'(k_edge + 2 + 160));
        check("b2b_data", 32'(data_a), 32'h0C3);

        // Reset during data bit 4.
        l0 = ld_a; f0 = fe_a;
        build(16, 8, 9'h05A, 1'b1, 0, 1'b0, 1, 1'b0);
        drive(0, 1 + 5 * 16 + 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_data", 32'(data_a), 32'd0);
        check("mr_load", 32'(load_a), 32'd0);
        check("mr_perr", 32'(perr_a), 32'd0);
        check("mr_ferr", 32'(ferr_a), 32'd0);
        check("mr_busy", 32'(busy_a), 32'd0);
        idle(20);
        check("mr_no_load", 32'(ld_a), 32'(l0));
        check("mr_no_ferr", 32'(fe_a), 32'(f0));
        build(16, 8, 9'h081, 1'b1, 0, 1'b0, 1, 1'b0);
        exp_a.push_back({1'b0, 9'h081});
        drive(0, pin_q.size());
        idle(6);
        check("mr_next_count", 32'(ld_a), 32'(l0 + 1));
        check("mr_next_data", 32'(data_a), 32'h081);

        check("a_sb_drained", 32'(exp_a.size()), 32'd0);
        check("b_sb_drained", 32'(exp_b.size()), 32'd0);
        check("c_sb_drained", 32'(exp_c.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
